// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: sequencer between EX and the multiply/divide unit.
// Latches one mult/div/madd/msub instruction, holds its operands steady while
// the unit runs, stalls the pipeline until done, and commits the result once.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_in,
  input  logic        ex_valid,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        md_done,
  input  logic [63:0] md_result,
  output logic [5:0]  md_funct,
  output logic [31:0] md_op1,
  output logic [31:0] md_op2,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo,
  output logic        md_flush,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        gpr_we,
  output logic [31:0] gpr_wdata,
  output logic        timeout_err
);

  // Decoded FUNCT_BUS codes; all nonzero so md_funct==0 unambiguously means idle.
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MADD  = 6'h1C;
  localparam logic [5:0] F_MADDU = 6'h1D;
  localparam logic [5:0] F_MSUB  = 6'h1E;
  localparam logic [5:0] F_MSUBU = 6'h1F;

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state, state_nx;
  logic [5:0]    funct_q;
  logic [31:0]   op1_q, op2_q, hi_q, lo_q;
  logic [63:0]   res_q;
  logic [CW-1:0] cnt_q;
  logic          is_md, launch, to_hit;

  // Recognise instructions that need the multiply/divide unit.
  always_comb begin
    is_md = 1'b0;
    case (ex_funct)
      F_MULT, F_MULTU, F_DIV, F_DIVU, F_MUL,
      F_MADD, F_MADDU, F_MSUB, F_MSUBU: is_md = 1'b1;
      default:                          is_md = 1'b0;
    endcase
  end

  assign launch = (state == S_IDLE) && ex_valid && is_md && !flush;
  assign to_hit = (state == S_BUSY) && !md_done && (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state and control outputs; flush overrides everything, and the
  // input-dependent outputs are forced low while reset is held.
  always_comb begin
    state_nx    = state;
    stall_req   = 1'b0;
    md_funct    = 6'd0;
    md_flush    = 1'b0;
    hilo_we     = 1'b0;
    gpr_we      = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) begin
          stall_req = 1'b1;
          state_nx  = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        md_funct  = funct_q;
        if (md_done) begin
          state_nx = S_DONE;
        end else if (to_hit) begin
          timeout_err = 1'b1;
          md_flush    = 1'b1;
          state_nx    = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall_in) begin
          state_nx = S_IDLE;
          if (funct_q == F_MUL) gpr_we  = 1'b1;
          else                  hilo_we = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx    = S_IDLE;
      stall_req   = 1'b0;
      md_flush    = 1'b1;
      hilo_we     = 1'b0;
      gpr_we      = 1'b0;
      timeout_err = 1'b0;
    end
    if (!rst) begin
      stall_req = 1'b0;
      md_flush  = 1'b0;
    end
  end

  // Operand latches, BUSY cycle counter and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      funct_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (launch) begin
        funct_q <= ex_funct;
        op1_q   <= ex_op1;
        op2_q   <= ex_op2;
        hi_q    <= hi_in;
        lo_q    <= lo_in;
        cnt_q   <= '0;
      end else if (state == S_BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state == S_BUSY && !flush) begin
        if (md_done)     res_q <= md_result;
        else if (to_hit) res_q <= '0;
      end
    end
  end

  assign md_op1    = op1_q;
  assign md_op2    = op2_q;
  assign md_hi     = hi_q;
  assign md_lo     = lo_q;
  assign hi_wdata  = res_q[63:32];
  assign lo_wdata  = res_q[31:0];
  assign gpr_wdata = res_q[31:0];

endmodule
